arbiter_rr_wt: RTL and testbench
================================

# arbiter_rr_wt

Weighted round-robin arbiter with burst grants. It is the parametrised successor to the single-cycle round-robin arbiter. Each of WIDTH requesters gets a registered one-hot grant and keeps it for up to its programmed weight in accepted beats (`ack`). Rotating priority then moves to the requester after the last owner. It sits in front of shared pipeline resources (CDB, memory port, issue slots), where bursts must not be split by per-cycle re-arbitration.

## Interface
- `WIDTH`, 16, number of requesters (≥2)
- `WEIGHT_W`, 4, bits per requester weight
- `IDX_W`, `$clog2(WIDTH)`, width of the owner index

- `clock`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous active-low reset; one clock, reset asynchronous and active-low, as decided
- `req`  in  WIDTH  per-requester request level
- `weight`  in  WIDTH*WEIGHT_W  per-requester beat budget; slice i is `[i*WEIGHT_W +: WEIGHT_W]`; value 0 is treated as 1
- `ack`  in  1  consumer accepted one beat from the current owner this cycle
- `gnt`  out  WIDTH  registered one-hot grant; all zero when idle
- `gnt_valid`  out  1  a grant is held (OR of `gnt`)
- `gnt_idx`  out  IDX_W  index of the owner; holds its last value when idle
- `credit_left`  out  WEIGHT_W  beats remaining for the owner, including the current beat

## Operation
- Two states.
  - IDLE: `gnt_valid`=0.
  - GRANT: owner = `gnt_idx`.
- Internal pointer `ptr` (IDX_W bits) marks the highest-priority index.
- Winner selection is combinational from `req` and `ptr`:
  - the lowest index i ≥ `ptr` with `req[i]`=1;
  - otherwise the lowest index overall with `req[i]`=1;
  - otherwise no winner.
- IDLE → GRANT when a winner exists.
  - `gnt`, `gnt_idx` load the winner.
  - `credit_left` loads max(`weight[winner]`, 1).
- In GRANT, a beat counts only when `ack`=1 and `req[owner]`=1. A counted beat decrements `credit_left`.
- Release happens in a GRANT cycle under either condition:
  - `req[owner]`=0 (any `ack` that cycle is ignored);
  - a counted beat with `credit_left`=1.
- On release:
  - `ptr` ← (owner+1) mod WIDTH; wrap from WIDTH-1 to 0;
  - the winner is recomputed in the same cycle using the new `ptr` and current `req`;
  - if a winner exists, GRANT reloads with it (zero-bubble handoff); otherwise → IDLE.
- The same requester wins again only if no other requester is asserting.
- `weight` is sampled only at grant load. Mid-burst changes take effect at that requester's next grant.
- New requests arriving mid-burst never preempt the owner.

## Timing
- Reset values (asynchronous, on `reset_n`=0): `gnt`=0, `gnt_valid`=0, `gnt_idx`=0, `credit_left`=0, `ptr`=0, state IDLE.
- Request to grant latency: 1 cycle. A `req` sampled at edge k gives `gnt` valid after edge k.
- Back-to-back handoff: the new grant is visible the cycle after the release cycle, with no idle cycle.
- Burst length with continuous `ack` and held `req`: exactly max(weight,1) cycles of grant per owner.
- Reset mid-burst drops the grant immediately, without waiting for a clock edge. The first grant after deassertion follows from `ptr`=0.
- `ack` while IDLE is ignored.

## Configuration
- `ARB_RR_WT_LOCK_EN` defined:
  - adds input `lock` (1 bit);
  - while `lock`=1 in GRANT, credit exhaustion does not release; `credit_left` saturates at 1;
  - `req[owner]`=0 still releases;
  - when `lock` falls, the normal rules resume with `credit_left`=1.
- `ARB_RR_WT_LOCK_EN` not defined:
  - no `lock` port;
  - release strictly by credit or request drop.

## Test plan
- Reset then `req`=0x0005, all weights 2, `ack`=1 continuously → `gnt` sequence 0x0001,0x0001,0x0004,0x0004,0x0001,…; `gnt_valid` never drops.
- `req`=0x8001, `gnt_idx`=15 releasing → pointer wraps to 0 and `gnt`=0x0001 next cycle.
- Owner 3 with weight 4, `ack` pulses on cycles 1,3 only, `req[3]` drops on cycle 5 → `credit_left` 4,3,3,2,2 and release on cycle 5. Next grant goes to the lowest requester at index ≥4, else wraps.
- Weight 0 on requester 2, sole requester, `ack`=1 → one-beat grants re-won each cycle: `gnt`=0x0004 continuously, `credit_left` reloads to 1.
- `reset_n` asserted mid-burst (owner 7, `credit_left`=3) → `gnt`=0 before the next edge. After release with `req`=0x0090, `gnt`=0x0010.
- With `ARB_RR_WT_LOCK_EN`: owner weight 1, `lock`=1 for 5 acked cycles → grant held, `credit_left`=1. `lock` falls with `ack`=1 → release that cycle.

Source files
------------

// File: rtl/arbiter_rr_wt_if.sv
// Request/grant bundle for arbiter_rr_wt; the lock input exists only with ARB_RR_WT_LOCK_EN.
// The master side drives requests, weights and acks; the slave side is the arbiter.
interface arbiter_rr_wt_if #(
  parameter int WIDTH    = 16,
  parameter int WEIGHT_W = 4,
  parameter int IDX_W    = $clog2(WIDTH)
);
  logic [WIDTH-1:0]          req;
  logic [WIDTH*WEIGHT_W-1:0] weight;
  logic                      ack;
`ifdef ARB_RR_WT_LOCK_EN
  logic                      lock;
`endif
  logic [WIDTH-1:0]          gnt;
  logic                      gnt_valid;
  logic [IDX_W-1:0]          gnt_idx;
  logic [WEIGHT_W-1:0]       credit_left;

`ifdef ARB_RR_WT_LOCK_EN
  modport master (output req, weight, ack, lock,
                  input  gnt, gnt_valid, gnt_idx, credit_left);
  modport slave  (input  req, weight, ack, lock,
                  output gnt, gnt_valid, gnt_idx, credit_left);
`else
  modport master (output req, weight, ack,
                  input  gnt, gnt_valid, gnt_idx, credit_left);
  modport slave  (input  req, weight, ack,
                  output gnt, gnt_valid, gnt_idx, credit_left);
`endif
endinterface

// File: rtl/arbiter_rr_wt.sv
// Weighted round-robin burst arbiter: registered one-hot grant one cycle after req, held for
// max(weight,1) acked beats, zero-bubble handoff; ARB_RR_WT_LOCK_EN adds lock to hold past credit.
module arbiter_rr_wt #(
  parameter int WIDTH    = 16,
  parameter int WEIGHT_W = 4,
  parameter int IDX_W    = $clog2(WIDTH)
) (
  input  logic            clock,
  input  logic            reset_n,
  arbiter_rr_wt_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;

  logic                 owner_req;
  logic                 beat;
  logic                 release_now;
  logic                 lock_hold;
  logic [IDX_W-1:0]     ptr_nxt;
  logic [IDX_W-1:0]     sel_ptr;
  logic                 win_vld;
  logic [IDX_W-1:0]     win_idx;
  logic [WEIGHT_W-1:0]  win_wt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      idx_q    <= '0;
      credit_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    idx_d       = idx_q;
    credit_d    = credit_q;
    ptr_d       = ptr_q;
`ifdef ARB_RR_WT_LOCK_EN
    lock_hold   = bus.lock;
`else
    lock_hold   = 1'b0;
`endif
    owner_req   = bus.req[idx_q];
    beat        = bus.ack && owner_req;
    release_now = 1'b0;

    if (state_q == GRANT) begin
      if (!owner_req) begin
        release_now = 1'b1;
      end else if (beat) begin
        // Under lock the last credit is kept rather than spent, so credit saturates at 1.
        if (credit_q == WEIGHT_W'(1) && !lock_hold)
          release_now = 1'b1;
        else if (credit_q > WEIGHT_W'(1))
          credit_d = credit_q - WEIGHT_W'(1);
      end
    end

    ptr_nxt = (idx_q == IDX_W'(WIDTH-1)) ? '0 : IDX_W'(idx_q + 1'b1);
    sel_ptr = release_now ? ptr_nxt : ptr_q;

    // Lowest requester overall, then overridden by the lowest at or above the pointer.
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = WIDTH-1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
    for (int i = WIDTH-1; i >= 0; i--) begin
      if (bus.req[i] && (i >= int'(sel_ptr)))
        win_idx = IDX_W'(i);
    end
    win_wt = bus.weight[win_idx*WEIGHT_W +: WEIGHT_W];

    if (state_q == IDLE || release_now) begin
      if (release_now)
        ptr_d = ptr_nxt;
      if (win_vld) begin
        state_d  = GRANT;
        gnt_d    = {{(WIDTH-1){1'b0}}, 1'b1} << win_idx;
        idx_d    = win_idx;
        credit_d = (win_wt == '0) ? WEIGHT_W'(1) : win_wt;
      end else begin
        state_d  = IDLE;
        gnt_d    = '0;
        credit_d = '0;
      end
    end
  end

  always_comb begin
    bus.gnt         = gnt_q;
    bus.gnt_valid   = |gnt_q;
    bus.gnt_idx     = idx_q;
    bus.credit_left = credit_q;
  end

endmodule

// File: tb/tb_arbiter_rr_wt.sv
// Bench for arbiter_rr_wt: directed scenarios plus random traffic against a queue-free
// behavioural model of the weighted round-robin rules (owner / credit / pointer as integers).
module tb_arbiter_rr_wt;

  localparam int W  = 16;
  localparam int WW = 4;

  logic           clock;
  logic           reset_n;
  logic [W-1:0]   req_r;
  logic [W*WW-1:0] wt_r;
  logic           ack_r;
  logic           lock_r;

  int vectors;
  int miscompares;

  // model state
  int m_owner;
  int m_last;
  int m_credit;
  int m_ptr;

  arbiter_rr_wt_if #(.WIDTH(W), .WEIGHT_W(WW)) bus ();

  assign bus.req    = req_r;
  assign bus.weight = wt_r;
  assign bus.ack    = ack_r;
`ifdef ARB_RR_WT_LOCK_EN
  assign bus.lock   = lock_r;
`endif

  arbiter_rr_wt #(.WIDTH(W), .WEIGHT_W(WW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  wire [W+WW+4:0] got = {bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.credit_left};

  function automatic int m_winner(int ptr);
    for (int k = 0; k < W; k++) begin
      int i;
      i = (ptr + k) % W;
      if (req_r[i]) return i;
    end
    return -1;
  endfunction

  function automatic int m_load(int i);
    int w;
    w = int'(wt_r[i*WW +: WW]);
    return (w < 1) ? 1 : w;
  endfunction

  task automatic m_reset();
    m_owner  = -1;
    m_last   = 0;
    m_credit = 0;
    m_ptr    = 0;
  endtask

  task automatic model_update();
    int w;
    bit rel;
    bit lk;
`ifdef ARB_RR_WT_LOCK_EN
    lk = lock_r;
`else
    lk = 1'b0;
`endif
    if (!reset_n) begin
      m_reset();
    end else if (m_owner < 0) begin
      w = m_winner(m_ptr);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_credit = m_load(w);
      end
    end else begin
      rel = 1'b0;
      if (!req_r[m_owner]) rel = 1'b1;
      else if (ack_r) begin
        if (m_credit == 1 && !lk) rel = 1'b1;
        else if (m_credit > 1) m_credit--;
      end
      if (rel) begin
        m_ptr = (m_owner + 1) % W;
        w = m_winner(m_ptr);
        if (w >= 0) begin
          m_owner = w; m_last = w; m_credit = m_load(w);
        end else begin
          m_owner = -1; m_credit = 0;
        end
      end
    end
  endtask

  function automatic logic [W+WW+4:0] exp_out();
    logic [W-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return {g, (m_owner >= 0), 4'(m_last), WW'(m_credit)};
  endfunction

  // one clock: model sees the same inputs the DUT samples; outputs read at the falling edge
  task automatic step();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    req_r = '0; ack_r = 1'b0; lock_r = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_r = 16'hA5C3; wt_r = {16{4'd3}}; ack_r = 1'b1; lock_r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (got !== 25'h0 || got !== exp_out()) begin
        miscompares++;
        $display("FAIL reset cyc%0d: got %h required %h", i, got, 25'h0);
      end
    end
    req_r = '0;
    reset_n = 1'b1;
  endtask

  task automatic test_rotation();
    logic [15:0] tbl [8];
    tbl = '{16'h0001, 16'h0001, 16'h0004, 16'h0004, 16'h0001, 16'h0001, 16'h0004, 16'h0004};
    apply_reset();
    wt_r = {16{4'd2}}; req_r = 16'h0005; ack_r = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if (got !== exp_out() || bus.gnt !== tbl[i] || bus.gnt_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL rotation cyc%0d: got %h required %h (gnt %h)", i, got, exp_out(), tbl[i]);
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    wt_r = {16{4'd1}}; req_r = 16'h8001; ack_r = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (got !== exp_out() || bus.gnt !== ((i % 2 == 0) ? 16'h0001 : 16'h8000)) begin
        miscompares++;
        $display("FAIL wrap cyc%0d: got %h required %h", i, got, exp_out());
      end
    end
  endtask

  task automatic test_partial_ack();
    logic [3:0] cred [6];
    logic       acks [6];
    cred = '{4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd4};
    acks = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    apply_reset();
    wt_r = {16{4'd4}}; wt_r[3*WW +: WW] = 4'd4; wt_r[4*WW +: WW] = 4'd4;
    req_r = 16'h0008;
    for (int i = 0; i < 6; i++) begin
      ack_r = acks[i];
      if (i == 5) req_r = 16'h0050;
      step();
      vectors++;
      if (got !== exp_out() || bus.credit_left !== cred[i] ||
          bus.gnt !== ((i == 5) ? 16'h0010 : 16'h0008)) begin
        miscompares++;
        $display("FAIL partial_ack cyc%0d: got %h required %h credit %0d", i, got, exp_out(), cred[i]);
      end
    end
  endtask

  task automatic test_weight_zero();
    apply_reset();
    wt_r = '0; req_r = 16'h0004; ack_r = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (got !== exp_out() || bus.gnt !== 16'h0004 || bus.credit_left !== 4'd1) begin
        miscompares++;
        $display("FAIL weight_zero cyc%0d: got %h required %h", i, got, exp_out());
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    wt_r = {16{4'd2}}; wt_r[7*WW +: WW] = 4'd5;
    req_r = 16'h0080; ack_r = 1'b0;
    step();
    ack_r = 1'b1;
    step();
    step();
    vectors++;
    if (got !== exp_out() || bus.credit_left !== 4'd3 || bus.gnt_idx !== 4'd7) begin
      miscompares++;
      $display("FAIL mid_burst_pre: got %h required %h", got, exp_out());
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.gnt !== 16'h0 || bus.gnt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: gnt %h valid %b required 0", bus.gnt, bus.gnt_valid);
    end
    m_reset();
    req_r = 16'h0090; ack_r = 1'b0;
    #1 reset_n = 1'b1;
    step();
    vectors++;
    if (got !== exp_out() || bus.gnt !== 16'h0010) begin
      miscompares++;
      $display("FAIL after_reset_grant: got %h required %h", got, exp_out());
    end
  endtask

`ifdef ARB_RR_WT_LOCK_EN
  task automatic test_lock();
    apply_reset();
    wt_r = {16{4'd1}}; req_r = 16'h0003; ack_r = 1'b1; lock_r = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (got !== exp_out() || bus.gnt !== 16'h0001 || bus.credit_left !== 4'd1) begin
        miscompares++;
        $display("FAIL lock_hold cyc%0d: got %h required %h", i, got, exp_out());
      end
    end
    lock_r = 1'b0;
    step();
    vectors++;
    if (got !== exp_out() || bus.gnt !== 16'h0002) begin
      miscompares++;
      $display("FAIL lock_fall: got %h required %h", got, exp_out());
    end
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0: req_r = W'($urandom);
        1: req_r = W'($urandom) & W'($urandom) & W'($urandom);
        2: req_r = req_r;
        default: req_r = req_r ^ (W'(1) << $urandom_range(0, W-1));
      endcase
      if ($urandom_range(0, 15) == 0) wt_r = {$urandom, $urandom};
      ack_r  = ($urandom_range(0, 3) != 0);
      lock_r = ($urandom_range(0, 4) == 0);
      reset_n = ($urandom_range(0, 199) != 0);
      step();
      vectors++;
      if (got !== exp_out()) begin
        miscompares++;
        $display("FAIL random cyc%0d: got %h required %h req %h", i, got, exp_out(), req_r);
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    m_reset();
    reset_n = 1'b0;
    req_r = '0; wt_r = '0; ack_r = 1'b0; lock_r = 1'b0;
    @(negedge clock);
    test_reset();
    test_rotation();
    test_wrap();
    test_partial_ack();
    test_weight_zero();
    test_reset_mid_burst();
`ifdef ARB_RR_WT_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
